// File: rtl/seq_divider_pkg.sv
// Shared types for seq_divider: FSM states, counter sizing,
// and divide-by-zero result constants.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam bit DBZ_SET = 1'b1;
  localparam bit DBZ_CLR = 1'b0;

  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider request/result bundle.
// master: start, signed_mode, dividend, divisor -> ready, done, results.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divide_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  ready, done, quotient, remainder,
    input  divide_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output ready, done, quotient, remainder,
    output divide_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// div_step: one combinational restoring-division iteration.
// in: rem, dsr, bit_in  out: rem_nx, q_bit
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dsr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_nx,
  output logic             q_bit
);
  logic [WIDTH:0] part;

  assign part  = {rem, bit_in};
  assign q_bit = part >= {1'b0, dsr};
  // The kept difference is below dsr, so
  // modulo-2^WIDTH subtraction is exact.
  assign rem_nx = q_bit ? part[WIDTH-1:0] - dsr
                        : part[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async low), bus (seq_divider_if.slave).
import div_pkg::*;

module seq_divider #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic             sign_q;
  logic             sign_r;
  logic             dbz;

  logic             eff;
  logic             sd;
  logic             sv;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;

  assign eff   = bus.signed_mode & SIGNED_EN;
  assign sd    = eff & bus.dividend[WIDTH-1];
  assign sv    = eff & bus.divisor[WIDTH-1];
  assign mag_a = sd ? -bus.dividend : bus.dividend;
  assign mag_b = sv ? -bus.divisor : bus.divisor;

  assign bus.ready = (state == IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem),
    .dsr    (dsr),
    .bit_in (acc[WIDTH-1]),
    .rem_nx (rem_nx),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      acc                <= '0;
      rem                <= '0;
      dsr                <= '0;
      sign_q             <= 1'b0;
      sign_r             <= 1'b0;
      dbz                <= 1'b0;
      bus.done           <= 1'b0;
      bus.quotient       <= '0;
      bus.remainder      <= '0;
      bus.divide_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            rem    <= '0;
            dsr    <= mag_b;
            sign_q <= sd ^ sv;
            sign_r <= sd;
            if (bus.divisor == '0) begin
              // Raw dividend is kept for the remainder.
              dbz   <= DBZ_SET;
              acc   <= bus.dividend;
              state <= FIX;
            end else begin
              dbz   <= DBZ_CLR;
              acc   <= mag_a;
              state <= CALC;
            end
          end
        end
        CALC: begin
          // acc shifts dividend bits out, quotient bits in.
          acc <= {acc[WIDTH-2:0], q_bit};
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dbz) begin
            bus.quotient  <= '1;
            bus.remainder <= acc;
          end else begin
            bus.quotient  <= sign_q ? -acc : acc;
            bus.remainder <= sign_r ? -rem : rem;
          end
          bus.divide_by_zero <= dbz;
          bus.done           <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
